// File: rtl/fifo_packetizer.sv
// Drains an async-read sample FIFO into header + PKTLEN sample packets on a valid/ready stream.
// Latency: header 1 cycle after the start condition; samples pass FIFO head -> o_data combinationally.
// Backpressure: beats hold while !i_ready, no pop. PKTIZER_TIMEOUT_EN adds an idle flush of short packets.
module fifo_packetizer #(
    parameter int BW        = 16,
    parameter int LGFLEN    = 4,
    parameter int PKTLEN    = 8,
    parameter int LGTIMEOUT = 10
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    output logic              o_fifo_rd,
    input  logic [BW-1:0]     i_fifo_data,
    input  logic              i_fifo_empty,
    input  logic [LGFLEN:0]   i_fifo_fill,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BW-1:0]     o_data,
    output logic              o_hdr,
    output logic              o_last,
    output logic              o_busy
);

    if (BW < 16 || PKTLEN < 1 || PKTLEN > 255 || PKTLEN > (1 << LGFLEN) || LGTIMEOUT < 1) begin : g_bad_param
        $error("fifo_packetizer: illegal parameter combination");
    end

    localparam logic [LGFLEN:0] FULL_FILL = (LGFLEN+1)'(PKTLEN);
    localparam logic [7:0]      FULL_LEN  = 8'(PKTLEN);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

    state_t        state_q;
    logic [BW-9:0] seq_q;
    logic [7:0]    len_q;
    logic [7:0]    rem_q;
    logic          valid_q;
    logic          hdr_q;
    logic          last_q;

    logic          start_d;
    logic [7:0]    start_len_d;

`ifdef PKTIZER_TIMEOUT_EN
    logic [LGTIMEOUT-1:0] idle_cnt_q;
    logic [LGTIMEOUT-1:0] idle_cnt_d;
    logic                 short_fill;
    logic                 timeout_hit;

    always_comb begin
        short_fill  = !i_fifo_empty && (i_fifo_fill < FULL_FILL);
        timeout_hit = (state_q == S_IDLE) && short_fill && (idle_cnt_q == '1);
        idle_cnt_d  = idle_cnt_q + LGTIMEOUT'(1);
        if (state_q != S_IDLE || !short_fill || timeout_hit) begin
            idle_cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    always_comb begin
        start_d     = (i_fifo_fill >= FULL_FILL);
        start_len_d = FULL_LEN;
`ifdef PKTIZER_TIMEOUT_EN
        if (timeout_hit) begin
            start_d     = 1'b1;
            start_len_d = 8'(i_fifo_fill);
        end
`endif
    end

    // last_q is precomputed one beat ahead so o_last is a register, not a compare on rem_q.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            hdr_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_d) begin
                        state_q <= S_HDR;
                        valid_q <= 1'b1;
                        hdr_q   <= 1'b1;
                        len_q   <= start_len_d;
                        rem_q   <= start_len_d;
                    end
                end
                S_HDR: begin
                    if (i_ready) begin
                        state_q <= S_DATA;
                        hdr_q   <= 1'b0;
                        last_q  <= (rem_q == 8'd1);
                    end
                end
                S_DATA: begin
                    if (i_ready) begin
                        rem_q  <= rem_q - 8'd1;
                        last_q <= (rem_q == 8'd2);
                        if (last_q) begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            seq_q   <= seq_q + (BW-8)'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                    hdr_q   <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid   = valid_q;
    assign o_hdr     = hdr_q;
    assign o_last    = last_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_fifo_rd = (state_q == S_DATA) && i_ready && !i_fifo_empty;

    always_comb begin
        o_data = '0;
        if (hdr_q) begin
            o_data = {seq_q, len_q};
        end else if (state_q == S_DATA) begin
            o_data = i_fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Bench for fifo_packetizer: behavioural async-read FIFO upstream, scoreboard of expected beats downstream.
module tb_fifo_packetizer;

    typedef struct packed {
        logic        hdr;
        logic        last;
        logic [15:0] dat;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        o_fifo_rd;
    logic [15:0] fifo_data;
    logic        fifo_empty;
    logic [4:0]  fifo_fill = 5'd0;
    logic        o_valid;
    logic        i_ready;
    logic [15:0] o_data;
    logic        o_hdr;
    logic        o_last;
    logic        o_busy;

    logic        fifo_wr;
    logic [15:0] fifo_wdat;
    logic [15:0] mem [16];
    logic [3:0]  rdp = 4'd0;
    logic [3:0]  wrp = 4'd0;
    int          overflow = 0;

    int    n_chk = 0;
    int    n_pass = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    beat_t e;
    int    exp_seq = 0;

    logic        stall_q = 1'b0;
    logic [17:0] held = '0;
    int          pops = 0;
    int          valid_cycles = 0;
    int          run = 0;
    int          idle_run = 0;
    int          last_run = 0;
    int          last_gap = 0;

    always #5 i_clk = ~i_clk;

    fifo_packetizer #(.BW(16), .LGFLEN(4), .PKTLEN(8), .LGTIMEOUT(10)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .o_fifo_rd    (o_fifo_rd),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .i_fifo_fill  (fifo_fill),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_hdr        (o_hdr),
        .o_last       (o_last),
        .o_busy       (o_busy)
    );

    // Upstream FIFO: 16 deep, head visible without a read cycle; never flushed by reset.
    assign fifo_empty = (fifo_fill == 5'd0);
    assign fifo_data  = mem[rdp];

    always @(posedge i_clk) begin
        logic rd_ok;
        logic wr_ok;
        rd_ok = o_fifo_rd && (fifo_fill != 5'd0);
        wr_ok = fifo_wr && ((fifo_fill != 5'd16) || rd_ok);
        if (fifo_wr && !wr_ok) overflow++;
        if (rd_ok) rdp <= rdp + 4'd1;
        if (wr_ok) begin
            mem[wrp] <= fifo_wdat;
            wrp      <= wrp + 4'd1;
        end
        if (wr_ok && !rd_ok) fifo_fill <= fifo_fill + 5'd1;
        else if (!wr_ok && rd_ok) fifo_fill <= fifo_fill - 5'd1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            stall_q  = 1'b0;
            run      = 0;
            idle_run = 0;
        end else begin
            if (o_valid) valid_cycles++;
            if (o_valid && i_ready) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 64'({o_hdr, o_last, o_data}), 64'(e));
                end
            end
            if (stall_q) chk("stall_hold", 64'({o_valid, o_hdr, o_last, o_data}), 64'({1'b1, held}));
            stall_q = o_valid && !i_ready;
            held    = {o_hdr, o_last, o_data};
            if (!i_ready || !o_valid || o_hdr) chk("rd_gate", 64'(o_fifo_rd), 64'(0));
            if (o_valid && !o_hdr) chk("empty_in_data", 64'(fifo_empty), 64'(0));
            if (o_fifo_rd) pops++;
            if (o_valid) begin
                if (run == 0) last_gap = idle_run;
                run++;
                idle_run = 0;
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                idle_run++;
            end
        end
    end

    task automatic push_beat(input logic hdr, input logic last, input logic [15:0] dat);
        beat_t b;
        b.hdr  = hdr;
        b.last = last;
        b.dat  = dat;
        exp_q.push_back(b);
    endtask

    task automatic push_pkt(input logic [15:0] first, input int len);
        push_beat(1'b1, 1'b0, {8'(exp_seq), 8'(len)});
        for (int i = 0; i < len; i++) push_beat(1'b0, (i == len - 1), first + 16'(i));
        exp_seq++;
    endtask

    task automatic write_seq(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_wr   = 1'b1;
            fifo_wdat = first + 16'(i);
            @(posedge i_clk);
            #1;
        end
        fifo_wr = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge i_clk);
            k++;
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        exp_seq   = 0;
        settle(2);
        i_reset_n = 1'b1;
        settle(1);
    endtask

    initial begin
        int p0;
        int v0;
        i_reset_n = 1'b0;
        i_ready   = 1'b0;
        fifo_wr   = 1'b0;
        fifo_wdat = 16'h0;
        #3;
        chk("reset_outputs", 64'({o_valid, o_hdr, o_last, o_busy, o_fifo_rd, o_data}), 64'(0));
        settle(2);
        i_reset_n = 1'b1;
        settle(1);

        // Full packet, ready held high.
        i_ready = 1'b1;
        push_pkt(16'h0101, 8);
        write_seq(16'h0101, 8);
        wait_drain("t1_drain", 100);
        settle(3);
        chk("t1_run_len", 64'(last_run), 64'(9));
        chk("t1_fifo_fill", 64'(fifo_fill), 64'(0));
        chk("t1_idle_outs", 64'({o_valid, o_busy, o_data}), 64'(0));

        // Same packet with ready toggling every cycle.
        do_reset();
        i_ready = 1'b0;
        p0 = pops;
        push_pkt(16'h0101, 8);
        write_seq(16'h0101, 8);
        for (int i = 0; i < 40; i++) begin
            i_ready = ~i_ready;
            settle(1);
        end
        i_ready = 1'b1;
        wait_drain("t2_drain", 100);
        settle(3);
        chk("t2_pops", 64'(pops - p0), 64'(8));
        chk("t2_fifo_fill", 64'(fifo_fill), 64'(0));

        // Back-to-back packets, then a third to confirm seq reached 2.
        do_reset();
        push_pkt(16'h0201, 8);
        push_pkt(16'h0209, 8);
        write_seq(16'h0201, 16);
        wait_drain("t3_drain", 100);
        settle(3);
        chk("t3_gap", 64'(last_gap), 64'(1));
        chk("t3_run_len", 64'(last_run), 64'(9));
        push_pkt(16'h0211, 8);
        write_seq(16'h0211, 8);
        wait_drain("t3_third", 100);
        settle(3);

        // Below threshold.
        do_reset();
        v0 = valid_cycles;
`ifdef PKTIZER_TIMEOUT_EN
        push_pkt(16'h0301, 5);
        write_seq(16'h0301, 5);
        settle(900);
        chk("t4_not_early", 64'(valid_cycles - v0), 64'(0));
        wait_drain("t4_short_pkt", 300);
        settle(3);
        chk("t4_fifo_fill", 64'(fifo_fill), 64'(0));
`else
        write_seq(16'h0301, 5);
        settle(2000);
        chk("t4_no_valid", 64'(valid_cycles - v0), 64'(0));
        chk("t4_fifo_fill", 64'(fifo_fill), 64'(5));
        push_pkt(16'h0301, 8);
        write_seq(16'h0306, 3);
        wait_drain("t4_fill_up", 100);
        settle(3);
`endif

        // Reset after the third data beat.
        do_reset();
        push_beat(1'b1, 1'b0, 16'h0008);
        for (int i = 0; i < 3; i++) push_beat(1'b0, 1'b0, 16'h0501 + 16'(i));
        write_seq(16'h0501, 8);
        wait_drain("t5_three_beats", 100);
        i_reset_n = 1'b0;
        exp_seq   = 0;
        #1;
        chk("t5_async_reset", 64'({o_valid, o_hdr, o_last, o_busy, o_fifo_rd, o_data}), 64'(0));
        chk("t5_fifo_kept", 64'(fifo_fill), 64'(5));
        settle(2);
        i_reset_n = 1'b1;
        settle(1);
        push_pkt(16'h0504, 8);
        write_seq(16'h0509, 3);
        wait_drain("t5_resume", 100);
        settle(3);

        // Continuous writes during DATA.
        do_reset();
        push_pkt(16'h0601, 8);
        push_pkt(16'h0609, 8);
        push_pkt(16'h0611, 8);
        write_seq(16'h0601, 24);
        wait_drain("t6_drain", 100);
        settle(3);
        chk("t6_overflow", 64'(overflow), 64'(0));
        chk("t6_fifo_fill", 64'(fifo_fill), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_packetizer.md
# fifo_packetizer

Drains an asynchronous-read synchronous FIFO (`sfifo`, `OPT_ASYNC_READ=1`) and emits framed packets on a valid/ready stream. Each packet is one header beat (sequence number and length) followed by `PKTLEN` sample beats, with the last beat flagged. The block sits directly downstream of the sample FIFO and feeds the host/DMA link of the SDR datapath. It is the only reader of that FIFO.

## Interface
- `BW`, 16: sample and stream word width; must be ≥ 16.
- `LGFLEN`, 4: log2 of the upstream FIFO depth; `i_fifo_fill` is `LGFLEN+1` bits.
- `PKTLEN`, 8: samples per full packet; 1 ≤ `PKTLEN` ≤ 2^`LGFLEN`, and `PKTLEN` ≤ 255.
- `LGTIMEOUT`, 10: log2 of the idle flush timeout in cycles (used only with `PKTIZER_TIMEOUT_EN`).
- `i_clk` in 1: the single clock; everything is on the rising edge.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `o_fifo_rd` out 1: FIFO pop strobe (connects to the FIFO `i_rd`).
- `i_fifo_data` in `BW`: FIFO head word, valid in the same cycle (FIFO `o_data`).
- `i_fifo_empty` in 1: FIFO empty flag (FIFO `o_empty`).
- `i_fifo_fill` in `LGFLEN+1`: FIFO occupancy (FIFO `o_fill`).
- `o_valid` out 1: stream beat valid.
- `i_ready` in 1: downstream accepts the beat.
- `o_data` out `BW`: stream beat.
- `o_hdr` out 1: the current beat is the header.
- `o_last` out 1: the current beat is the final sample of the packet.
- `o_busy` out 1: a packet is in progress (state ≠ IDLE).

## Operation
- **State machine:** IDLE, HDR, DATA.
- **IDLE:**
  - Go to HDR when `i_fifo_fill >= PKTLEN`.
  - On that transition, latch `len = PKTLEN` and `remaining = PKTLEN`.
  - While in IDLE, `o_valid=0` and `o_data=0`.
- **HDR:**
  - `o_valid=1`, `o_hdr=1`, `o_data = {seq[BW-9:0], len[7:0]}`.
  - `len` is zero-extended into the low byte; `seq` has `BW-8` bits.
  - Go to DATA when `i_ready` is high.
- **DATA:**
  - `o_valid=1` and `o_data = i_fifo_data`, passed through combinationally.
  - `o_fifo_rd = i_ready`.
  - `o_last = (remaining == 1)`.
  - Each accepted beat decrements `remaining`.
  - When the `o_last` beat is accepted, go to IDLE and increment `seq` (wraps modulo 2^(`BW-8`)).
- **Availability guarantee:** `len ≤ fill` when the packet starts, and this block is the sole reader. `i_fifo_empty` is therefore never high in DATA. The block still gates the pop: `o_fifo_rd = 0` if `i_fifo_empty`. Verification asserts that `i_fifo_empty` stays low in DATA.
- **Backpressure:** while `o_valid && !i_ready`, `o_data`, `o_hdr` and `o_last` hold steady. No pop occurs, so the FIFO head is unchanged.
- **Pop gating:** `o_fifo_rd` is never high outside DATA.
- **Simultaneous upstream writes:** writes during DATA do not affect `len`. The next start decision is made with the new fill while in IDLE.
- **Reset mid-packet:** the packet is aborted, with no `o_last`.
  - State returns to IDLE and `seq` returns to 0.
  - FIFO contents are not flushed by this block. Any remaining samples begin a fresh packet.

## Timing
- **Reset values:** `o_valid=0`, `o_hdr=0`, `o_last=0`, `o_busy=0`, `o_fifo_rd=0`, `o_data=0`, state=IDLE, `seq=0`, `remaining=0`.
- **Start latency:** the header is presented 1 cycle after the cycle in which the IDLE start condition is seen.
- **Packet length:** with `i_ready` held high, a packet occupies exactly `len+1` consecutive cycles, followed by at least 1 IDLE cycle before the next header.
- **Combinational paths:** `i_ready` → `o_fifo_rd` and `i_fifo_data` → `o_data` (both are FIFO-local). All state updates are registered.
- **Sequence width:** `seq` increments only on acceptance of an `o_last` beat.

## Configuration
- **`PKTIZER_TIMEOUT_EN` defined:**
  - An idle counter of `LGTIMEOUT` bits counts cycles spent in IDLE with `!i_fifo_empty` and `i_fifo_fill < PKTLEN`.
  - It clears when the FIFO is empty or on leaving IDLE.
  - When it reaches 2^`LGTIMEOUT`−1, the block starts a short packet with `len = remaining = i_fifo_fill` (1…`PKTLEN`−1).
  - The header `len` field reports that short length.
- **Not defined:** only full `PKTLEN` packets are ever sent. Residual samples wait in the FIFO indefinitely, and the counter is not built.

## Test plan
- **Full packet, no backpressure:** reset, write 8 samples 0x0101..0x0108, `i_ready=1`.
  - Header 0x0008 with `o_hdr`, then 0x0101..0x0108.
  - `o_last` on 0x0108, 9 consecutive valid cycles, FIFO empty afterwards.
- **Backpressure:** same stimulus, `i_ready` toggling 1/0 every cycle.
  - Identical beat sequence.
  - `o_data` stable during stalls, no `o_fifo_rd` while `i_ready=0`, 8 pops total.
- **Back-to-back packets:** write 16 samples, `i_ready=1`.
  - Headers 0x0008 then 0x0108, exactly one IDLE cycle between packets, `seq`=2 at the end.
- **Below threshold:** write 5 samples, hold 2000 cycles.
  - Without the macro: `o_valid` never asserts.
  - With `PKTIZER_TIMEOUT_EN` and `LGTIMEOUT`=10: header 0x0005 appears about 1024 cycles after the first write, followed by 5 samples with `o_last` on the 5th.
- **Reset mid-packet:** pull `i_reset_n` low asynchronously after the 3rd data beat.
  - All outputs are 0 immediately.
  - After release, the remaining 5 samples plus 3 new ones form a packet with header 0x0008 (`seq`=0).
- **Writes during DATA:** continuous upstream writes at 1 per cycle during DATA.
  - The FIFO never overflows when sized ≥ 2×`PKTLEN`.
  - `len` is unaffected, and `i_fifo_empty` never rises in DATA.
